mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM pipeline stage, directly downstream of the EX/MEM pipeline register.
- Consumes that register's datapath and control outputs, resolves branches (PCSrc), and performs data-memory loads/stores over a req/ack handshake.
- Stalls upstream until each access completes.
- Contains the MEM/WB pipeline register that feeds writeback.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles dmem_req stays high without dmem_ack before the access is aborted.
- ADDR_W, 32: data memory address width; the low ADDR_W bits of ALUresult are used.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- in_valid  in  1  EX/MEM holds a live instruction (0 = bubble).
- EXtoMEM_zero  in  1  ALU zero flag.
- EXtoMEM_ALUresult  in  32  address or ALU result.
- EXtoMEM_WriteData  in  32  store data (forwarded rt value).
- EXtoMEM_Branch_Addr  in  32  branch target.
- EXtoMEM_RegDest  in  5  destination register.
- MEM_Branch, MEM_MemRead, MEM_MemWrite, MEM_MemtoReg, MEM_RegWrite  in  1 each  control signals.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  ADDR_W  address.
- dmem_wdata  out  32  store data.
- dmem_rdata  in  32  load data, valid when dmem_ack=1.
- dmem_ack  in  1  access complete.
- mem_stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM.
- PCSrc  out  1  take branch.
- branch_target  out  32  equals EXtoMEM_Branch_Addr.
- mem_err  out  1  sticky timeout / misalignment flag.
- MEMtoWB_ReadData  out  32  load data.
- MEMtoWB_ALUresult  out  32  ALU result.
- MEMtoWB_RegDest  out  5  destination register.
- WB_MemtoReg, WB_RegWrite  out  1 each  WB control.

Behaviour:
- Reset (rst=0, async): FSM to IDLE, timeout counter 0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, mem_err=0, all MEMtoWB_* and WB_* outputs 0. An in-flight access is dropped; ack after reset is ignored.
- access = in_valid & (MEM_MemRead | MEM_MemWrite). If both are set, the write wins; read data is not captured, and RegWrite still passes.
- PCSrc = in_valid & MEM_Branch & EXtoMEM_zero. Combinational; forced 0 while state != IDLE.
- FSM states: IDLE, ACCESS.
- IDLE, no access: MEM/WB loads inputs every clock (latency 1). If in_valid=0, WB_RegWrite=0 and WB_MemtoReg=0 are loaded.
- IDLE, access:
  - mem_stall=1 combinationally.
  - At the edge: register dmem_req=1, dmem_we=MemWrite, dmem_addr, dmem_wdata; counter=0; go to ACCESS.
  - MEM/WB loads a bubble (RegWrite=0).
- ACCESS, dmem_ack=0:
  - mem_stall=1, request held stable, counter+1, MEM/WB loads a bubble.
  - Upstream must hold EX/MEM stable.
- ACCESS, dmem_ack=1:
  - mem_stall=0 this cycle.
  - At the edge: MEM/WB loads inputs, with ReadData=dmem_rdata (0 for stores); dmem_req=0; go to IDLE.
  - Minimum load/store latency: 2 cycles, 1 stall cycle.
- ACCESS, counter == TIMEOUT_CYCLES-1 with no ack:
  - Abort: dmem_req=0, mem_err<=1, MEM/WB loads a bubble, go to IDLE, mem_stall=0 in that cycle.
  - The instruction is retired as a no-op.
- dmem_ack while dmem_req=0 is ignored.
- Back-to-back accesses: the next access is seen in IDLE one cycle after the ack. dmem_req drops for at least 1 cycle between accesses.
- mem_err is cleared only by reset.
- Counter width is $clog2(TIMEOUT_CYCLES)+1; it never wraps.

Optional Feature:
- MEM_ALIGN_CHECK_EN defined: an access with EXtoMEM_ALUresult[1:0] != 0 issues no request and causes no stall. Set mem_err<=1; MEM/WB loads a bubble.
- Not defined: the address is passed unchecked; low bits go to dmem_addr as-is.

Decomposition:
- Shared package mips_pipe_pkg:
  - FSM state enum (IDLE, ACCESS).
  - WORD_W=32, REG_ADDR_W=5.
  - Bubble constant for MEM/WB control.
- One natural sub-module: memwb_reg, the MEM/WB register with load/bubble select and async active-low reset.

Test Plan:
1. Reset check: reset asserted mid-ACCESS with dmem_req=1 -> next cycle dmem_req=0, state IDLE, all outputs 0; a later ack causes no write to MEM/WB.
2. Branch pass-through: in_valid=1, Branch=1, zero=1, Branch_Addr=0x0000_0040 -> PCSrc=1, branch_target=0x40, no stall. With zero=0 -> PCSrc=0.
3. Delayed load: load at ALUresult=0x100, ack 3 cycles after request with rdata=0xDEADBEEF:
   - mem_stall high for 3 cycles, bubbles in WB meanwhile.
   - Then MEMtoWB_ReadData=0xDEADBEEF, WB_RegWrite=1, WB_MemtoReg=1.
4. Fast store: store with WriteData=0x12345678, ack in the first ACCESS cycle -> dmem_we=1, dmem_wdata=0x12345678, exactly 1 stall cycle, WB_RegWrite=0.
5. Timeout: load with no ack, TIMEOUT_CYCLES=16 -> abort after 16 ACCESS cycles, mem_err=1 (sticky), stall released, bubble in WB.
6. Alignment (MEM_ALIGN_CHECK_EN): load at ALUresult=0x102 -> dmem_req stays 0, no stall, mem_err=1. Without the macro: request issued with dmem_addr=0x102.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline MEM stage: FSM encodings,
// widths and the MEM/WB register payload with its bubble value.
package mips_pipe_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StAccess = 1'b1;

  typedef struct packed {
    logic [WORD_W-1:0]     read_data;
    logic [WORD_W-1:0]     alu_result;
    logic [REG_ADDR_W-1:0] reg_dest;
    logic                  mem_to_reg;
    logic                  reg_write;
  } memwb_t;

  // A bubble retires nothing: no register write, no memory-to-register select.
  localparam memwb_t MemwbBubble = '0;

  function automatic memwb_t memwb_pack(input logic [WORD_W-1:0]     read_data,
                                        input logic [WORD_W-1:0]     alu_result,
                                        input logic [REG_ADDR_W-1:0] reg_dest,
                                        input logic                  mem_to_reg,
                                        input logic                  reg_write);
    memwb_t r;
    r.read_data  = read_data;
    r.alu_result = alu_result;
    r.reg_dest   = reg_dest;
    r.mem_to_reg = mem_to_reg;
    r.reg_write  = reg_write;
    return r;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and the data memory
// (slave). A request is held stable until ack.
interface mem_access_stage_if #(
  parameter int unsigned ADDR_W = 32
) ();
  import mips_pipe_pkg::*;

  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [WORD_W-1:0] dmem_wdata;
  logic [WORD_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_rdata,
    input  dmem_ack
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_rdata,
    output dmem_ack
  );

endinterface

// File: rtl/memwb_reg.sv
// MEM/WB pipeline register: loads the next payload every clock, or a bubble
// when the stage has nothing to retire.
module memwb_reg
  import mips_pipe_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   bubble,
  input  memwb_t d,
  output memwb_t q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= MemwbBubble;
    end else if (bubble) begin
      q <= MemwbBubble;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: branch resolution, req/ack data-memory access with
// timeout abort, and the MEM/WB register. Optional MEM_ALIGN_CHECK_EN rejects
// word accesses whose address low bits are non-zero.
module mem_access_stage
  import mips_pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  in_valid,
  input  logic                  EXtoMEM_zero,
  input  logic [WORD_W-1:0]     EXtoMEM_ALUresult,
  input  logic [WORD_W-1:0]     EXtoMEM_WriteData,
  input  logic [WORD_W-1:0]     EXtoMEM_Branch_Addr,
  input  logic [REG_ADDR_W-1:0] EXtoMEM_RegDest,
  input  logic                  MEM_Branch,
  input  logic                  MEM_MemRead,
  input  logic                  MEM_MemWrite,
  input  logic                  MEM_MemtoReg,
  input  logic                  MEM_RegWrite,

  mem_access_stage_if.master    dmem,

  output logic                  mem_stall,
  output logic                  PCSrc,
  output logic [WORD_W-1:0]     branch_target,
  output logic                  mem_err,

  output logic [WORD_W-1:0]     MEMtoWB_ReadData,
  output logic [WORD_W-1:0]     MEMtoWB_ALUresult,
  output logic [REG_ADDR_W-1:0] MEMtoWB_RegDest,
  output logic                  WB_MemtoReg,
  output logic                  WB_RegWrite
);

  localparam int unsigned       CntW   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CntW-1:0]   CntMax = CntW'(TIMEOUT_CYCLES - 1);

  logic [0:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;

  logic              access;
  logic              misaligned;
  logic              wb_bubble;
  memwb_t            wb_d, wb_q;

  assign access = in_valid & (MEM_MemRead | MEM_MemWrite);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = access & (|EXtoMEM_ALUresult[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    wb_bubble = 1'b0;
    mem_stall = 1'b0;
    wb_d      = memwb_pack('0, EXtoMEM_ALUresult, EXtoMEM_RegDest,
                           in_valid & MEM_MemtoReg, in_valid & MEM_RegWrite);

    unique case (state_q)
      StIdle: begin
        if (misaligned) begin
          err_d     = 1'b1;
          wb_bubble = 1'b1;
        end else if (access) begin
          mem_stall = 1'b1;
          req_d     = 1'b1;
          we_d      = MEM_MemWrite;
          addr_d    = EXtoMEM_ALUresult[ADDR_W-1:0];
          wdata_d   = EXtoMEM_WriteData;
          cnt_d     = '0;
          state_d   = StAccess;
          wb_bubble = 1'b1;
        end
      end
      StAccess: begin
        // Request is always high here, so ack needs no further qualification.
        if (dmem.dmem_ack) begin
          req_d   = 1'b0;
          state_d = StIdle;
          if (!MEM_MemWrite) begin
            wb_d.read_data = dmem.dmem_rdata;
          end
        end else if (cnt_q == CntMax) begin
          req_d     = 1'b0;
          err_d     = 1'b1;
          wb_bubble = 1'b1;
          state_d   = StIdle;
        end else begin
          mem_stall = 1'b1;
          cnt_d     = cnt_q + CntW'(1);
          wb_bubble = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  memwb_reg u_memwb_reg (
    .clk    (clk),
    .rst    (rst),
    .bubble (wb_bubble),
    .d      (wb_d),
    .q      (wb_q)
  );

  // Branches resolve only while no memory access is outstanding.
  assign PCSrc         = (state_q == StIdle) & in_valid & MEM_Branch & EXtoMEM_zero;
  assign branch_target = EXtoMEM_Branch_Addr;
  assign mem_err       = err_q;

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;

  assign MEMtoWB_ReadData  = wb_q.read_data;
  assign MEMtoWB_ALUresult = wb_q.alu_result;
  assign MEMtoWB_RegDest   = wb_q.reg_dest;
  assign WB_MemtoReg       = wb_q.mem_to_reg;
  assign WB_RegWrite       = wb_q.reg_write;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: transaction-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_mem_access_stage;
  import mips_pipe_pkg::*;

  localparam int unsigned T = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid, EXtoMEM_zero;
  logic [31:0] EXtoMEM_ALUresult, EXtoMEM_WriteData, EXtoMEM_Branch_Addr;
  logic [4:0]  EXtoMEM_RegDest;
  logic        MEM_Branch, MEM_MemRead, MEM_MemWrite, MEM_MemtoReg, MEM_RegWrite;
  logic        mem_stall, PCSrc, mem_err, WB_MemtoReg, WB_RegWrite;
  logic [31:0] branch_target, MEMtoWB_ReadData, MEMtoWB_ALUresult;
  logic [4:0]  MEMtoWB_RegDest;

  mem_access_stage_if #(.ADDR_W(32)) dmem_if ();

  mem_access_stage #(.TIMEOUT_CYCLES(T), .ADDR_W(32)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_valid            (in_valid),
    .EXtoMEM_zero        (EXtoMEM_zero),
    .EXtoMEM_ALUresult   (EXtoMEM_ALUresult),
    .EXtoMEM_WriteData   (EXtoMEM_WriteData),
    .EXtoMEM_Branch_Addr (EXtoMEM_Branch_Addr),
    .EXtoMEM_RegDest     (EXtoMEM_RegDest),
    .MEM_Branch          (MEM_Branch),
    .MEM_MemRead         (MEM_MemRead),
    .MEM_MemWrite        (MEM_MemWrite),
    .MEM_MemtoReg        (MEM_MemtoReg),
    .MEM_RegWrite        (MEM_RegWrite),
    .dmem                (dmem_if),
    .mem_stall           (mem_stall),
    .PCSrc               (PCSrc),
    .branch_target       (branch_target),
    .mem_err             (mem_err),
    .MEMtoWB_ReadData    (MEMtoWB_ReadData),
    .MEMtoWB_ALUresult   (MEMtoWB_ALUresult),
    .MEMtoWB_RegDest     (MEMtoWB_RegDest),
    .WB_MemtoReg         (WB_MemtoReg),
    .WB_RegWrite         (WB_RegWrite)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction and how long it has waited.
  logic        m_busy, m_req, m_we, m_err, m_mtr, m_rw;
  int          m_waited;
  logic [31:0] m_addr, m_wdata, m_rd, m_alu;
  logic [4:0]  m_dest;

  function automatic logic is_misaligned();
`ifdef MEM_ALIGN_CHECK_EN
    return in_valid && (MEM_MemRead || MEM_MemWrite) && (EXtoMEM_ALUresult[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 0; m_req <= 0; m_we <= 0; m_err <= 0; m_mtr <= 0; m_rw <= 0;
      m_waited <= 0; m_addr <= 0; m_wdata <= 0; m_rd <= 0; m_alu <= 0; m_dest <= 0;
    end else if (!m_busy) begin
      if (is_misaligned()) begin
        m_err <= 1; {m_rd, m_alu, m_dest, m_mtr, m_rw} <= '0;
      end else if (in_valid && (MEM_MemRead || MEM_MemWrite)) begin
        m_busy <= 1; m_waited <= 0; m_req <= 1; m_we <= MEM_MemWrite;
        m_addr <= EXtoMEM_ALUresult; m_wdata <= EXtoMEM_WriteData;
        {m_rd, m_alu, m_dest, m_mtr, m_rw} <= '0;
      end else begin
        m_rd <= 0; m_alu <= EXtoMEM_ALUresult; m_dest <= EXtoMEM_RegDest;
        m_mtr <= in_valid & MEM_MemtoReg; m_rw <= in_valid & MEM_RegWrite;
      end
    end else if (dmem_if.dmem_ack) begin
      m_busy <= 0; m_req <= 0;
      m_rd <= MEM_MemWrite ? 32'h0 : dmem_if.dmem_rdata;
      m_alu <= EXtoMEM_ALUresult; m_dest <= EXtoMEM_RegDest;
      m_mtr <= in_valid & MEM_MemtoReg; m_rw <= in_valid & MEM_RegWrite;
    end else if (m_waited + 1 == T) begin
      m_busy <= 0; m_req <= 0; m_err <= 1; {m_rd, m_alu, m_dest, m_mtr, m_rw} <= '0;
    end else begin
      m_waited <= m_waited + 1; {m_rd, m_alu, m_dest, m_mtr, m_rw} <= '0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      logic exp_stall, exp_pc;
      if (!m_busy) begin
        exp_stall = in_valid && (MEM_MemRead || MEM_MemWrite) && !is_misaligned();
        exp_pc    = in_valid && MEM_Branch && EXtoMEM_zero;
      end else begin
        exp_stall = !dmem_if.dmem_ack && (m_waited + 1 < T);
        exp_pc    = 1'b0;
      end
      chk("model_stall", mem_stall, exp_stall);
      chk("model_pcsrc", PCSrc, exp_pc);
      chk("model_target", branch_target, EXtoMEM_Branch_Addr);
      chk("model_req", dmem_if.dmem_req, m_req);
      chk("model_err", mem_err, m_err);
      chk("model_wb_rd", MEMtoWB_ReadData, m_rd);
      chk("model_wb_alu", MEMtoWB_ALUresult, m_alu);
      chk("model_wb_dest", MEMtoWB_RegDest, m_dest);
      chk("model_wb_ctl", {WB_MemtoReg, WB_RegWrite}, {m_mtr, m_rw});
      if (m_req) begin
        chk("model_we", dmem_if.dmem_we, m_we);
        chk("model_addr", dmem_if.dmem_addr, m_addr);
        chk("model_wdata", dmem_if.dmem_wdata, m_wdata);
      end
    end
  end

  logic [31:0] rdata_val;
  logic        cap_req_seen, cap_we;
  logic [31:0] cap_addr, cap_wdata;
  int          stalls;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic iv, input logic br, input logic z, input logic rd,
                        input logic wr, input logic mtr, input logic rw,
                        input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] dest);
    in_valid = iv; MEM_Branch = br; EXtoMEM_zero = z; MEM_MemRead = rd; MEM_MemWrite = wr;
    MEM_MemtoReg = mtr; MEM_RegWrite = rw; EXtoMEM_ALUresult = alu;
    EXtoMEM_WriteData = wd; EXtoMEM_RegDest = dest;
  endtask

  // ack_wait: request-high cycles without ack before ack is given (-1 = never).
  task automatic run_access(input int ack_wait, output int n_stall);
    int  req_cycles;
    bit  done;
    n_stall = 0; req_cycles = 0; done = 0; cap_req_seen = 0;
    chk("req_low_at_issue", dmem_if.dmem_req, 1'b0);
    for (int c = 0; c < 40 && !done; c++) begin
      dmem_if.dmem_ack   = (ack_wait >= 0) && dmem_if.dmem_req && (req_cycles == ack_wait);
      dmem_if.dmem_rdata = dmem_if.dmem_ack ? rdata_val : 32'h0;
      @(negedge clk);
      if (mem_stall) n_stall++;
      if (dmem_if.dmem_req) begin
        req_cycles++; cap_req_seen = 1; cap_we = dmem_if.dmem_we;
        cap_addr = dmem_if.dmem_addr; cap_wdata = dmem_if.dmem_wdata;
      end
      done = !mem_stall;
      next_cycle();
    end
    dmem_if.dmem_ack = 0; dmem_if.dmem_rdata = 0;
    chk("access_completes", done, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    EXtoMEM_Branch_Addr = 0; dmem_if.dmem_ack = 0; dmem_if.dmem_rdata = 0; rdata_val = 0;
    repeat (2) next_cycle();
    @(negedge clk);
    chk("rst_req", dmem_if.dmem_req, 0);
    chk("rst_addr", dmem_if.dmem_addr, 0);
    chk("rst_err", mem_err, 0);
    chk("rst_wb", {MEMtoWB_ReadData, WB_RegWrite, WB_MemtoReg} != 0, 0);
    next_cycle();
    rst = 1;

    // Branch pass-through
    set_ex(1, 1, 1, 0, 0, 0, 0, 0, 0, 0); EXtoMEM_Branch_Addr = 32'h40;
    @(negedge clk);
    chk("br_pcsrc_taken", PCSrc, 1); chk("br_target", branch_target, 32'h40);
    chk("br_no_stall", mem_stall, 0);
    next_cycle();
    EXtoMEM_zero = 0;
    @(negedge clk); chk("br_pcsrc_not_taken", PCSrc, 0);
    next_cycle();

    // R-type passes through in one cycle
    set_ex(1, 0, 0, 0, 0, 0, 1, 32'h55, 0, 7);
    next_cycle();
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rtype_alu", MEMtoWB_ALUresult, 32'h55); chk("rtype_dest", MEMtoWB_RegDest, 7);
    chk("rtype_rw", WB_RegWrite, 1);
    next_cycle();
    @(negedge clk); chk("bubble_rw", WB_RegWrite, 0);
    next_cycle();

    // Delayed load: three stall cycles
    set_ex(1, 0, 0, 1, 0, 1, 1, 32'h100, 0, 3); rdata_val = 32'hDEADBEEF;
    run_access(2, stalls);
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("load_stalls", stalls, 3); chk("load_addr", cap_addr, 32'h100);
    chk("load_rd", MEMtoWB_ReadData, 32'hDEADBEEF);
    chk("load_ctl", {WB_RegWrite, WB_MemtoReg}, 2'b11); chk("load_dest", MEMtoWB_RegDest, 3);
    next_cycle();

    // Fast store
    set_ex(1, 0, 0, 0, 1, 0, 0, 32'h200, 32'h12345678, 0); rdata_val = 32'hFFFFFFFF;
    run_access(0, stalls);
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("store_stalls", stalls, 1); chk("store_we", cap_we, 1);
    chk("store_wdata", cap_wdata, 32'h12345678);
    chk("store_rw", WB_RegWrite, 0); chk("store_rd", MEMtoWB_ReadData, 0);
    next_cycle();

    // Back-to-back loads
    set_ex(1, 0, 0, 1, 0, 1, 1, 32'h104, 0, 4); rdata_val = 32'hA5A50001;
    run_access(1, stalls);
    set_ex(1, 0, 0, 1, 0, 1, 1, 32'h108, 0, 5); rdata_val = 32'h00005A5A;
    run_access(0, stalls);
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("b2b_rd", MEMtoWB_ReadData, 32'h00005A5A); chk("b2b_dest", MEMtoWB_RegDest, 5);
    next_cycle();

    // Misaligned load
    set_ex(1, 0, 0, 1, 0, 1, 1, 32'h102, 0, 6); rdata_val = 32'h0BADF00D;
    run_access(0, stalls);
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
`ifdef MEM_ALIGN_CHECK_EN
    chk("align_stalls", stalls, 0); chk("align_no_req", cap_req_seen, 0);
    chk("align_err", mem_err, 1); chk("align_rw", WB_RegWrite, 0);
`else
    chk("align_stalls", stalls, 1); chk("align_addr", cap_addr, 32'h102);
    chk("align_err", mem_err, 0); chk("align_rd", MEMtoWB_ReadData, 32'h0BADF00D);
`endif
    next_cycle();

    // Timeout
    set_ex(1, 0, 0, 1, 0, 1, 1, 32'h300, 0, 8);
    run_access(-1, stalls);
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("tmo_stalls", stalls, 16); chk("tmo_err", mem_err, 1);
    chk("tmo_rw", WB_RegWrite, 0); chk("tmo_req", dmem_if.dmem_req, 0);
    repeat (3) next_cycle();
    @(negedge clk); chk("tmo_err_sticky", mem_err, 1);
    next_cycle();

    // Reset in the middle of an access
    set_ex(1, 0, 0, 1, 0, 1, 1, 32'h400, 0, 9);
    repeat (3) next_cycle();
    @(negedge clk); chk("mid_req_high", dmem_if.dmem_req, 1);
    next_cycle();
    rst = 0; set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("mid_rst_req", dmem_if.dmem_req, 0); chk("mid_rst_err", mem_err, 0);
    chk("mid_rst_stall", mem_stall, 0);
    chk("mid_rst_wb", {MEMtoWB_ReadData, MEMtoWB_ALUresult, WB_RegWrite} != 0, 0);
    next_cycle();
    rst = 1; dmem_if.dmem_ack = 1; dmem_if.dmem_rdata = 32'hBAD0BAD0;
    next_cycle();
    @(negedge clk);
    chk("late_ack_rd", MEMtoWB_ReadData, 0); chk("late_ack_rw", WB_RegWrite, 0);
    chk("late_ack_req", dmem_if.dmem_req, 0);
    next_cycle();
    dmem_if.dmem_ack = 0; dmem_if.dmem_rdata = 0;
    repeat (2) next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
